// File: rtl/fifo_ctrl.sv
// Synchronous FIFO controller: pointers, occupancy count, status flags and
// sticky error flags for an external FIFO_Memory with combinational read.
module fifo_ctrl #(
  parameter int ADDR_SIZE = 4,
  parameter int AF_LEVEL  = 12,
  parameter int AE_LEVEL  = 4
) (
  input  logic                 wclk,
  input  logic                 wrst,
  input  logic                 winc,
  input  logic                 rinc,
  input  logic                 clr_err,
  output logic                 wclk_en,
  output logic [ADDR_SIZE-1:0] waddr,
  output logic [ADDR_SIZE-1:0] raddr,
  output logic                 wfull,
  output logic                 rempty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [ADDR_SIZE:0]   count,
  output logic                 overflow,
  output logic                 underflow
);
  localparam int                DEPTH   = 1 << ADDR_SIZE;
  localparam logic [ADDR_SIZE:0] DEPTH_C = (ADDR_SIZE+1)'(DEPTH);
  localparam logic [ADDR_SIZE:0] AF_C    = (ADDR_SIZE+1)'(AF_LEVEL);
  localparam logic [ADDR_SIZE:0] AE_C    = (ADDR_SIZE+1)'(AE_LEVEL);

  logic [ADDR_SIZE:0] wptr, rptr, count_nxt;
  logic               push_ok, pop_ok;

  // A push into a full FIFO is fine when a pop frees a slot in the same cycle.
  assign push_ok = winc & (~wfull | rinc);
  assign pop_ok  = rinc & ~rempty;
  assign wclk_en = push_ok & ~wrst;
  assign waddr   = wptr[ADDR_SIZE-1:0];
  assign raddr   = rptr[ADDR_SIZE-1:0];

  always_comb begin
    count_nxt = count;
    case ({push_ok, pop_ok})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      wfull        <= 1'b0;
      rempty       <= 1'b1;
      almost_full  <= (AF_LEVEL == 0);
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      count        <= count_nxt;
      // Flags come from the next-state count so they line up with count.
      wfull        <= (count_nxt == DEPTH_C);
      rempty       <= (count_nxt == '0);
      almost_full  <= (count_nxt >= AF_C);
      almost_empty <= (count_nxt <= AE_C);
      // Set has priority over clear.
      overflow     <= (winc & ~push_ok) | (overflow  & ~clr_err);
      underflow    <= (rinc & ~pop_ok)  | (underflow & ~clr_err);
    end
  end
endmodule
